// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner with frame-based debounce and press pulse
module keypad_scan #(
  parameter int SCAN_DIV        = 25000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [4:0] key,
  output logic [4:0] key_pulse
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] FULL = SW'(DEBOUNCE_FRAMES);
  // Nibble (row*4 + col) holds the key code for that switch position.
  localparam logic [63:0] CODES = 64'hDF0E_C987_B654_A321;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [4:0]    frame_q, frame_d, cand_q, cand_d, key_q, key_d, pulse_q, pulse_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          last, frame_end, hit;
  logic [1:0]    row;
  logic [4:0]    raw;
  // Scan timing, first-hit frame capture, debounce and pulse generation.
  always_comb begin
    last      = cnt_q == LAST;
    frame_end = last && col_q == 2'd3;
    cnt_d     = last ? '0 : cnt_q + 1'b1;
    col_d     = col_q + {1'b0, last};
    hit       = ~&sync2_q;
    row       = !sync2_q[0] ? 2'd0 : !sync2_q[1] ? 2'd1 : !sync2_q[2] ? 2'd2 : 2'd3;
    raw       = frame_q[4] ? frame_q : hit ? {1'b1, CODES[{row, col_q, 2'b00} +: 4]} : 5'h00;
    frame_d   = frame_end ? 5'h00 : last ? raw : frame_q;
    cand_d    = frame_end ? raw : cand_q;
    stab_d    = !frame_end ? stab_q : raw != cand_q ? SW'(1) : stab_q == FULL ? FULL : stab_q + 1'b1;
    key_d     = (frame_end && stab_d == FULL && cand_d != key_q) ? cand_d : key_q;
    pulse_d   = (key_d != key_q && key_d[4]) ? key_d : 5'h00;
    key_col   = ~(4'b0001 << col_q);
  end
  // State registers; rows pass through a two-flop synchroniser idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      col_q   <= 2'd0;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      frame_q <= 5'h00;
      cand_q  <= 5'h00;
      stab_q  <= '0;
      key_q   <= 5'h00;
      pulse_q <= 5'h00;
    end else begin
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      sync1_q <= key_row;
      sync2_q <= sync1_q;
      frame_q <= frame_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      key_q   <= key_d;
      pulse_q <= pulse_d;
    end
  end
  assign key       = key_q;
  assign key_pulse = pulse_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad model driving keypad_scan, frame-level reference model and pulse scoreboard
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FRAME = 4 * SD;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_row, key_col;
  logic [4:0]  key, key_pulse;
  logic [15:0] pressed = '0;
  int          checks = 0;
  int          passed = 0;
  logic [3:0]  codes [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
  int          n = 0;
  logic [4:0]  exp_key = 5'h00;
  logic [4:0]  hist[$];
  logic [4:0]  exp_q[$];

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .key(key), .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed switch at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++) key_row[r] = ~|(pressed[r*4 +: 4] & ~key_col);
  end

  function automatic logic [4:0] frame_raw(logic [15:0] p);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (p[r*4+c]) return {1'b1, codes[r*4+c]};
    return 5'h00;
  endfunction

  // Reference: key takes a value once the last DF frame results agree and differ from key.
  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      exp_key = 5'h00;
      hist.delete();
      exp_q.delete();
    end else begin
      n++;
      if (n % FRAME == 0) begin
        bit same;
        hist.push_back(frame_raw(pressed));
        if (hist.size() > DF) void'(hist.pop_front());
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        if (hist.size() == DF && same && hist[0] != exp_key) begin
          exp_key = hist[0];
          if (exp_key[4]) exp_q.push_back(exp_key);
        end
      end
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: level checks every cycle, pulses popped from the scoreboard when presented or due.
  always @(posedge clk) begin
    logic [3:0] ec;
    #1;
    ec = ~(4'b0001 << ((n / SD) % 4));
    chk("key", key, exp_key);
    chk("key_col", key_col, ec);
    if (key_pulse != 5'h00 || exp_q.size() != 0)
      chk("key_pulse", key_pulse, exp_q.size() != 0 ? exp_q.pop_front() : 5'h00);
  end

  task automatic hold(logic [15:0] p, int k);
    pressed = p;
    repeat (k * FRAME) @(negedge clk);
  endtask

  task automatic mid_reset(int offset, int len);
    repeat (offset) @(negedge clk);
    rst = 1'b1;
    repeat (len) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(16'h0010, 5);
    hold(16'h0000, 4);
    hold(16'h2000, 2);
    hold(16'h0000, 3);
    hold(16'h0104, 4);
    hold(16'h0000, 3);
    hold(16'h0010, 4);
    hold(16'h0001, 3);
    hold(16'h0000, 3);
    pressed = 16'h0010;
    repeat (FRAME) @(negedge clk);
    mid_reset(8, 3);
    hold(16'h0010, 3);
    hold(16'h0000, 3);
    repeat (40) begin
      logic [15:0] p;
      int kind;
      kind = $urandom_range(0, 3);
      p = kind == 0 ? 16'h0 : 16'h1 << $urandom_range(0, 15);
      if (kind == 3) p = p | (16'h1 << $urandom_range(0, 15));
      hold(p, $urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) mid_reset($urandom_range(1, FRAME - 1), $urandom_range(1, 4));
    end
    hold(16'h0000, 4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
